// File: rtl/div_pkg.sv
// div_pkg: shared width default, FSM encoding and result field ranges for div_arbiter
package div_pkg;
    localparam int DEF_DW = 16;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;
    localparam int QUO_LSB = 0;
    localparam int QUO_MSB = DEF_DW - 1;
    localparam int REM_LSB = DEF_DW;
    localparam int REM_MSB = 2 * DEF_DW - 1;
endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        any = |req;
        // scan farthest-first so the closest request to ptr is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one Divider, with divide-by-zero and timeout handling
module div_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*DW-1:0]   req_dividend,
    input  logic [NUM_REQ*DW-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2*DW-1:0]         rsp_result,
    output logic                    rsp_dbz,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    div_control,
    output logic [DW-1:0]           div_dividend,
    output logic [DW-1:0]           div_divisor,
    input  logic                    div_validity,
    input  logic [2*DW-1:0]         div_result
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d, owner_q, owner_d, idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                any, accept, vld_ok, expired;
    logic [DW-1:0]       dvd_q, dvd_d, dvs_q, dvs_d, sel_dvd, sel_dvs;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DW-1:0]     res_q, res_d;
    logic                dbz_q, dbz_d, to_q, to_d, rv_q, rv_d;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // a stale validity flag from the previous op is ignored in the first BUSY cycle
    always_comb begin
        sel_dvd = DW'(req_dividend >> (DW * idx));
        sel_dvs = DW'(req_divisor >> (DW * idx));
        accept  = state_q == IDLE && any;
        vld_ok  = div_validity && cnt_q != '0;
        expired = cnt_q == CW'(TIMEOUT - 1);
        state_d = state_q == IDLE ? (any ? (sel_dvs == '0 ? RELEASE : BUSY) : IDLE) :
                  state_q == BUSY ? ((vld_ok || expired) ? RELEASE : BUSY) : IDLE;
    end

    always_comb begin
        req_ready    = (state_q == IDLE && !rst) ? gnt : '0;
        div_control  = state_q == BUSY;
        busy         = state_q != IDLE;
        rsp_valid    = rv_q ? NUM_REQ'(1) << owner_q : '0;
        rsp_result   = res_q;
        rsp_dbz      = dbz_q;
        rsp_timeout  = to_q;
        div_dividend = dvd_q;
        div_divisor  = dvs_q;
    end

    always_comb begin
        ptr_d   = accept ? (idx == IW'(NUM_REQ - 1) ? '0 : idx + IW'(1)) : ptr_q;
        owner_d = accept ? idx : owner_q;
        dvd_d   = accept ? sel_dvd : dvd_q;
        dvs_d   = accept ? sel_dvs : dvs_q;
        cnt_d   = (state_q == BUSY && state_d == BUSY) ? cnt_q + CW'(1) : '0;
        rv_d    = state_d == RELEASE;
        dbz_d   = accept && sel_dvs == '0;
        to_d    = state_q == BUSY && !vld_ok && expired;
        res_d   = dbz_d ? {sel_dvd, {DW{1'b1}}} : (state_q == BUSY && vld_ok) ? div_result : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
            rv_q    <= rv_d;
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: random and directed traffic against a latency/arithmetic model of the arbiter
module tb_div_arbiter;
    localparam int NR = 2;
    localparam int DW = 16;
    localparam int TO = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [NR*DW-1:0]  req_dividend = '0, req_divisor = '0;
    logic [2*DW-1:0]   rsp_result, div_result;
    logic              rsp_dbz, rsp_timeout, busy, div_control, div_validity;
    logic [DW-1:0]     div_dividend, div_divisor;

    int checks = 0, errors = 0, cyc = 0;
    int lat = 2;
    bit hold = 1'b0;

    always #5 clk = ~clk;

    div_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout), .busy(busy),
        .div_control(div_control), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_validity(div_validity), .div_result(div_result)
    );

    // Divider stub: result appears lat cycles into a run; hold keeps a stale flag between runs
    logic        stub_vld = 1'b0;
    logic [31:0] stub_res = '0;
    int          stub_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            stub_vld <= 1'b0;
            stub_cnt <= 0;
        end else if (div_control) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == lat - 1) begin
                stub_vld <= 1'b1;
                stub_res <= {div_dividend % div_divisor, div_dividend / div_divisor};
            end
        end else begin
            stub_cnt <= 0;
            if (!hold) stub_vld <= 1'b0;
        end
    end
    assign div_validity = stub_vld;
    assign div_result   = stub_res;

    task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // behavioural model: one op in flight, response lands at a computed cycle
    bit          m_fly = 1'b0, m_dbz, m_to;
    int          m_ptr = 0, m_acc, m_rsp, m_own;
    logic [31:0] m_res;
    logic [NR-1:0] e_rdy, e_rv;
    bit          e_busy, e_ctl;
    int          w;
    logic [15:0] ma, mb;

    task model_step();
        cyc++;
        if (rst) begin
            m_fly = 1'b0;
            m_ptr = 0;
            return;
        end
        w = -1;
        if (!m_fly)
            for (int k = 0; k < NR; k++)
                if (w < 0 && ((req_valid >> ((m_ptr + k) % NR)) & NR'(1)) != '0) w = (m_ptr + k) % NR;
        e_rdy  = (w >= 0) ? NR'(1) << w : '0;
        e_rv   = (m_fly && cyc == m_rsp) ? NR'(1) << m_own : '0;
        e_busy = m_fly && cyc > m_acc;
        e_ctl  = e_busy && !m_dbz && cyc < m_rsp;
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("busy", busy, e_busy);
        chk("div_control", div_control, e_ctl);
        if (e_rv != '0) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_dbz", rsp_dbz, m_dbz);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
        if (m_fly && cyc == m_rsp) m_fly = 1'b0;
        if (w >= 0) begin
            ma    = 16'(req_dividend >> (w * DW));
            mb    = 16'(req_divisor >> (w * DW));
            m_fly = 1'b1;
            m_acc = cyc;
            m_own = w;
            m_ptr = (w + 1) % NR;
            m_dbz = mb == 0;
            m_to  = !m_dbz && lat + 1 > TO;
            m_res = m_dbz ? {ma, 16'hFFFF} : m_to ? 32'd0 : {ma % mb, ma / mb};
            m_rsp = cyc + (m_dbz ? 1 : m_to ? TO + 1 : lat + 2);
        end
    endtask

    task set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_dividend = (req_dividend & ~(32'hFFFF << (i * DW))) | (32'(a) << (i * DW));
        req_divisor  = (req_divisor & ~(32'hFFFF << (i * DW))) | (32'(b) << (i * DW));
        req_valid    = req_valid | (NR'(1) << i);
    endtask

    task clr_req(input int i);
        req_valid = req_valid & ~(NR'(1) << i);
    endtask

    task wait_grant(output int g);
        int n;
        n = 0;
        g = -1;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 200);
        for (int k = 0; k < NR; k++) if (((req_ready >> k) & NR'(1)) != '0) g = k;
    endtask

    task wait_idle();
        int n, quiet;
        @(posedge clk);
        #1 req_valid = '0;
        n = 0;
        quiet = 0;
        while (quiet < 2 && n < 200) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 2) fail("wait_idle");
    endtask

    task do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                output int n, output logic [31:0] res, output logic dbz,
                output logic to, output logic ctl);
        int g;
        @(posedge clk);
        #1 set_req(i, a, b);
        n = -1; res = '0; dbz = 1'b0; to = 1'b0; ctl = 1'b0;
        wait_grant(g);
        if (g != i) begin
            fail("run_op_accept");
            return;
        end
        @(posedge clk);
        #1 clr_req(i);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ctl |= div_control;
        end while (((rsp_valid >> i) & NR'(1)) == '0 && n < 100);
        if (((rsp_valid >> i) & NR'(1)) == '0) n = -1;
        res = rsp_result;
        dbz = rsp_dbz;
        to  = rsp_timeout;
    endtask

    task rand_phase(input int ncyc);
        logic [NR-1:0] acc;
        logic [15:0]   a, b;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (((acc >> i) & NR'(1)) != '0 || ((req_valid >> i) & NR'(1)) == '0) begin
                    a = 16'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom) >> $urandom_range(0, 14);
                    if ($urandom_range(0, 99) < 40) set_req(i, a, b);
                    else clr_req(i);
                end else if ($urandom_range(0, 99) < 3) clr_req(i);
            end
        end
    endtask

    int          n, g;
    logic [31:0] res;
    logic        dbz, to, ctl;
    int          lats[6] = '{1, 3, 5, TO - 1, TO, 1000};

    initial begin
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ctl", div_control, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_result", rsp_result, 0);
        chk("reset_ready", req_ready, 0);

        run_op(0, 16'd51, 16'd5, n, res, dbz, to, ctl);
        chk("t1_latency", n, 4);
        chk("t1_result", res, 32'h0001_000A);
        chk("t1_dbz", dbz, 0);
        chk("t1_timeout", to, 0);
        chk("t1_ctl_seen", ctl, 1);

        run_op(1, 16'd100, 16'd0, n, res, dbz, to, ctl);
        chk("t3_latency", n, 1);
        chk("t3_result", res, 32'h0064_FFFF);
        chk("t3_dbz", dbz, 1);
        chk("t3_ctl_seen", ctl, 0);

        lat = 1000;
        run_op(0, 16'd7, 16'd3, n, res, dbz, to, ctl);
        chk("t4_latency", n, TO + 1);
        chk("t4_result", res, 0);
        chk("t4_timeout", to, 1);
        lat = 2;

        hold = 1'b1;
        lat = 1;
        run_op(0, 16'd100, 16'd7, n, res, dbz, to, ctl);
        chk("t6_first_result", res, 32'h0002_000E);
        run_op(0, 16'd200, 16'd7, n, res, dbz, to, ctl);
        chk("t6_second_latency", n, 3);
        chk("t6_second_result", res, 32'h0004_001C);
        hold = 1'b0;
        lat = 2;
        wait_idle();

        do_reset();
        set_req(0, 16'd60, 16'd7);
        set_req(1, 16'd61, 16'd7);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk("t2_grant", g, k % 2);
        end
        wait_idle();

        lat = 1000;
        @(posedge clk);
        #1 set_req(0, 16'd9, 16'd2);
        wait_grant(g);
        chk("t5_first_grant", g, 0);
        @(posedge clk);
        #1 clr_req(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_ctl", div_control, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        repeat (45) @(negedge clk);
        lat = 2;
        @(posedge clk);
        #1 set_req(0, 16'd9, 16'd2);
        set_req(1, 16'd8, 16'd3);
        wait_grant(g);
        chk("t5_grant_after_reset", g, 0);
        wait_idle();

        hold = 1'b1;
        lat = 1;
        rand_phase(300);
        wait_idle();
        hold = 1'b0;
        foreach (lats[p]) begin
            lat = lats[p];
            rand_phase(250);
            wait_idle();
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
